// File: rtl/program_loader.sv
// Byte-stream command loader: decodes load/run commands from the UART receiver and drives
// the core's instruction/data memory write ports and run enable.
`timescale 1ns/1ps
module program_loader #(
   parameter int unsigned ADDR_STEP      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] insn_addr,
   output logic [31:0] insn_din,
   output logic        insn_we,
   output logic [31:0] data_addr,
   output logic [31:0] data_din,
   output logic        data_we,
   output logic        run,
   output logic        busy,
   output logic        error,
   output logic [31:0] words_loaded
);

   typedef enum logic [1:0] {StIdle, StAddr, StLen, StPayload} state_e;

   localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] AddrStep    = 32'(ADDR_STEP);

   state_e      state_q, state_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] addr_ptr_q, addr_ptr_d;
   logic [31:0] words_left_q, words_left_d;
   logic [31:0] idle_cnt_q, idle_cnt_d;
   logic        target_q, target_d;  // 0: instruction memory, 1: data memory
   logic        run_q, run_d;
   logic        error_q, error_d;
   logic [31:0] insn_addr_q, insn_addr_d;
   logic [31:0] insn_din_q, insn_din_d;
   logic        insn_we_q, insn_we_d;
   logic [31:0] data_addr_q, data_addr_d;
   logic [31:0] data_din_q, data_din_d;
   logic        data_we_q, data_we_d;
   logic [31:0] words_loaded_q, words_loaded_d;

   logic [31:0] full_word;
   logic        expire;

   always_comb begin
      state_d        = state_q;
      byte_idx_d     = byte_idx_q;
      shift_d        = shift_q;
      addr_ptr_d     = addr_ptr_q;
      words_left_d   = words_left_q;
      idle_cnt_d     = idle_cnt_q;
      target_d       = target_q;
      run_d          = run_q;
      error_d        = error_q;
      insn_addr_d    = insn_addr_q;
      insn_din_d     = insn_din_q;
      insn_we_d      = 1'b0;
      data_addr_d    = data_addr_q;
      data_din_d     = data_din_q;
      data_we_d      = 1'b0;
      words_loaded_d = words_loaded_q;

      // Incoming byte lands in bits 31:24, so after four bytes the first is in bits 7:0.
      full_word = {rx_data, shift_q[31:8]};
      expire    = (TIMEOUT_CYCLES != 0) && (state_q != StIdle) && (idle_cnt_q == TimeoutLast);

      if (state_q == StIdle || rx_valid) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + 32'd1;
      end

      // Expiry takes priority over a coincident strobe.
      if (expire) begin
         state_d    = StIdle;
         error_d    = 1'b1;
         byte_idx_d = '0;
         idle_cnt_d = '0;
      end else if (rx_valid) begin
         unique case (state_q)
            StIdle: begin
               case (rx_data)
                  8'h01, 8'h02: begin
                     target_d   = (rx_data == 8'h02);
                     run_d      = 1'b0;
                     state_d    = StAddr;
                     byte_idx_d = '0;
                  end
                  8'h03:   run_d   = 1'b1;
                  8'h04:   run_d   = 1'b0;
                  default: error_d = 1'b1;
               endcase
            end
            StAddr: begin
               shift_d    = full_word;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  addr_ptr_d = full_word;
                  state_d    = StLen;
                  byte_idx_d = '0;
               end
            end
            StLen: begin
               shift_d    = full_word;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  words_left_d = full_word;
                  state_d      = (full_word == '0) ? StIdle : StPayload;
                  byte_idx_d   = '0;
               end
            end
            StPayload: begin
               shift_d    = full_word;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  if (target_q) begin
                     data_we_d   = 1'b1;
                     data_addr_d = addr_ptr_q;
                     data_din_d  = full_word;
                  end else begin
                     insn_we_d   = 1'b1;
                     insn_addr_d = addr_ptr_q;
                     insn_din_d  = full_word;
                  end
                  addr_ptr_d     = addr_ptr_q + AddrStep;
                  words_loaded_d = words_loaded_q + 32'd1;
                  words_left_d   = words_left_q - 32'd1;
                  if (words_left_q == 32'd1) begin
                     state_d = StIdle;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         byte_idx_q     <= '0;
         shift_q        <= '0;
         addr_ptr_q     <= '0;
         words_left_q   <= '0;
         idle_cnt_q     <= '0;
         target_q       <= 1'b0;
         run_q          <= 1'b0;
         error_q        <= 1'b0;
         insn_addr_q    <= '0;
         insn_din_q     <= '0;
         insn_we_q      <= 1'b0;
         data_addr_q    <= '0;
         data_din_q     <= '0;
         data_we_q      <= 1'b0;
         words_loaded_q <= '0;
      end else begin
         state_q        <= state_d;
         byte_idx_q     <= byte_idx_d;
         shift_q        <= shift_d;
         addr_ptr_q     <= addr_ptr_d;
         words_left_q   <= words_left_d;
         idle_cnt_q     <= idle_cnt_d;
         target_q       <= target_d;
         run_q          <= run_d;
         error_q        <= error_d;
         insn_addr_q    <= insn_addr_d;
         insn_din_q     <= insn_din_d;
         insn_we_q      <= insn_we_d;
         data_addr_q    <= data_addr_d;
         data_din_q     <= data_din_d;
         data_we_q      <= data_we_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign insn_addr    = insn_addr_q;
   assign insn_din     = insn_din_q;
   assign insn_we      = insn_we_q;
   assign data_addr    = data_addr_q;
   assign data_din     = data_din_q;
   assign data_we      = data_we_q;
   assign run          = run_q;
   assign busy         = (state_q != StIdle);
   assign error        = error_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load frames, run control, errors, timeout, wrap, reset.
`timescale 1ns/1ps
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [31:0] insn_addr, insn_din, data_addr, data_din, words_loaded;
   logic        insn_we, data_we, run, busy, error;

   int total = 0;
   int bad = 0;
   int both_we = 0;
   logic [31:0] ia[$], id[$], da[$], dd[$];

   program_loader #(.ADDR_STEP(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
      .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
      .run(run), .busy(busy), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Record every write pulse seen between edges.
   always @(negedge clk) begin
      if (!reset) begin
         if (insn_we) begin ia.push_back(insn_addr); id.push_back(insn_din); end
         if (data_we) begin da.push_back(data_addr); dd.push_back(data_din); end
         if (insn_we && data_we) both_we++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      ia.delete(); id.delete(); da.delete(); dd.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      bit fell;
      idle(2);
      chk("reset_insn_we", {31'd0, insn_we}, 32'd0);
      chk("reset_run", {31'd0, run}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_words", words_loaded, 32'd0);
      reset = 1'b0;
      idle(2);

      // Instruction load of two words at base 0
      clear_log();
      send(8'h01);
      chk("t1_busy_after_cmd", {31'd0, busy}, 32'd1);
      send_word(32'h0000_0000);
      send_word(32'h0000_0002);
      send_word(32'h0000_0013);
      send_word(32'h0010_0093);
      idle(2);
      chk("t1_insn_count", ia.size(), 32'd2);
      if (ia.size() == 2) begin
         chk("t1_addr0", ia[0], 32'h0000_0000);
         chk("t1_din0", id[0], 32'h0000_0013);
         chk("t1_addr1", ia[1], 32'h0000_0004);
         chk("t1_din1", id[1], 32'h0010_0093);
      end
      chk("t1_data_count", da.size(), 32'd0);
      chk("t1_words", words_loaded, 32'd2);
      chk("t1_busy", {31'd0, busy}, 32'd0);

      // Data load then run
      clear_log();
      send(8'h02);
      send_word(32'h0000_0010);
      send_word(32'h0000_0001);
      send_word(32'hDEAD_BEEF);
      idle(2);
      chk("t2_data_count", da.size(), 32'd1);
      if (da.size() == 1) begin
         chk("t2_addr", da[0], 32'h0000_0010);
         chk("t2_din", dd[0], 32'hDEAD_BEEF);
      end
      chk("t2_insn_count", ia.size(), 32'd0);
      chk("t2_run_before", {31'd0, run}, 32'd0);
      send(8'h03);
      chk("t2_run_after", {31'd0, run}, 32'd1);
      chk("t2_busy", {31'd0, busy}, 32'd0);

      // Zero length frame halts the core
      clear_log();
      send(8'h01);
      chk("t3_run_dropped", {31'd0, run}, 32'd0);
      send_word(32'h0000_0000);
      send_word(32'h0000_0000);
      idle(2);
      chk("t3_busy", {31'd0, busy}, 32'd0);
      chk("t3_writes", ia.size() + da.size(), 32'd0);
      chk("t3_error", {31'd0, error}, 32'd0);
      chk("t3_words", words_loaded, 32'd3);

      // Bad command, then a normal data load
      clear_log();
      send(8'h7F);
      chk("t4_error", {31'd0, error}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      send(8'h02);
      send_word(32'h0000_0100);
      send_word(32'h0000_0001);
      send_word(32'h1234_5678);
      idle(2);
      chk("t4_data_count", da.size(), 32'd1);
      if (da.size() == 1) begin
         chk("t4_addr", da[0], 32'h0000_0100);
         chk("t4_din", dd[0], 32'h1234_5678);
      end
      chk("t4_error_sticky", {31'd0, error}, 32'd1);
      chk("t4_words", words_loaded, 32'd4);

      // Timeout mid-address
      do_reset();
      clear_log();
      chk("t5_error_cleared", {31'd0, error}, 32'd0);
      send(8'h01);
      send(8'hAA);
      send(8'hBB);
      idle(10);
      chk("t5_still_busy", {31'd0, busy}, 32'd1);
      fell = 1'b0;
      for (int i = 0; i < 10 && !fell; i++) begin
         @(negedge clk);
         if (!busy) fell = 1'b1;
      end
      chk("t5_timeout_fired", {31'd0, fell}, 32'd1);
      chk("t5_error", {31'd0, error}, 32'd1);
      chk("t5_writes", ia.size() + da.size(), 32'd0);
      send(8'h01);
      send_word(32'h0000_0020);
      send_word(32'h0000_0001);
      send_word(32'h1122_3344);
      idle(2);
      chk("t5_reload_count", ia.size(), 32'd1);
      if (ia.size() == 1) begin
         chk("t5_reload_addr", ia[0], 32'h0000_0020);
         chk("t5_reload_din", id[0], 32'h1122_3344);
      end
      chk("t5_words", words_loaded, 32'd1);

      // Address wrap past 2^32
      clear_log();
      send(8'h01);
      send_word(32'hFFFF_FFFC);
      send_word(32'h0000_0002);
      send_word(32'h0000_0001);
      send_word(32'h0000_0002);
      idle(2);
      chk("t6_count", ia.size(), 32'd2);
      if (ia.size() == 2) begin
         chk("t6_addr0", ia[0], 32'hFFFF_FFFC);
         chk("t6_addr1", ia[1], 32'h0000_0000);
         chk("t6_din1", id[1], 32'h0000_0002);
      end

      // Same frame, asynchronous reset between the two words
      clear_log();
      send(8'h01);
      send_word(32'hFFFF_FFFC);
      send_word(32'h0000_0002);
      send_word(32'h0000_0001);
      send(8'h05);
      send(8'h06);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t7_insn_addr", insn_addr, 32'd0);
      chk("t7_insn_din", insn_din, 32'd0);
      chk("t7_words", words_loaded, 32'd0);
      chk("t7_busy", {31'd0, busy}, 32'd0);
      chk("t7_error", {31'd0, error}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(10);
      chk("t7_count", ia.size(), 32'd1);
      chk("t7_words_after", words_loaded, 32'd0);
      chk("never_both_we", both_we, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
